// File: rtl/axis_sc_packetizer.sv
// axis_sc_packetizer
//
// Re-packetizes AXI-Stream bursts into packets of cfg_spp items. The final
// packet of a burst is shorter when the burst length is not a multiple of
// cfg_spp. Each packet carries a timestamp equal to the burst's starting
// timestamp plus the number of items already emitted in the burst. The
// packet also carries a byte length and an end-of-burst flag.
//
// Ports
//   ce_clk, ce_rst_n      clock, asynchronous active-low reset
//   cfg_spp               items per packet, latched at each packet start (0 acts as 1)
//   s_axis_*              input stream: tdata, tlast (end of burst), tvalid/tready,
//                         ttimestamp/thas_time (sampled on the burst's first item)
//   m_axis_*              output stream: tdata, tlast (end of packet), tvalid/tready,
//                         ttimestamp/thas_time, tlength (bytes), teob (last packet of burst)
//   pkt_count             number of packets emitted, wraps at 2^32
module axis_sc_packetizer #(
    parameter int unsigned NUM_CHAN = 1,
    parameter int unsigned ITEM_W   = 32,
    parameter int unsigned SPP_W    = 16
) (
    input  logic                         ce_clk,
    input  logic                         ce_rst_n,
    input  logic [SPP_W-1:0]             cfg_spp,
    input  logic [NUM_CHAN*ITEM_W-1:0]   s_axis_tdata,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [63:0]                  s_axis_ttimestamp,
    input  logic                         s_axis_thas_time,
    output logic [NUM_CHAN*ITEM_W-1:0]   m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [63:0]                  m_axis_ttimestamp,
    output logic                         m_axis_thas_time,
    output logic [15:0]                  m_axis_tlength,
    output logic                         m_axis_teob,
    output logic [31:0]                  pkt_count
);

    localparam int unsigned DataW     = NUM_CHAN * ITEM_W;
    localparam int unsigned ItemBytes = DataW / 8;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    // Burst / packet tracking state
    logic [0:0]       state_q, state_d;
    logic [SPP_W-1:0] cnt_q, cnt_d;         // items already in the open packet
    logic [SPP_W-1:0] spp_q, spp_d;         // spp latched for the open packet
    logic [63:0]      pkt_ts_q, pkt_ts_d;   // timestamp of the open packet
    logic [63:0]      nxt_ts_q, nxt_ts_d;   // timestamp of the next item in the burst
    logic             has_time_q, has_time_d;
    logic             rdy_q;                // low until the first edge after reset release

    // Output register stage
    logic [DataW-1:0] m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic             m_valid_q, m_valid_d;
    logic [63:0]      m_ts_q, m_ts_d;
    logic             m_has_time_q, m_has_time_d;
    logic [15:0]      m_len_q, m_len_d;
    logic             m_eob_q, m_eob_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;

    logic             s_fire;
    logic             m_fire;
    logic             out_en;
    logic             pkt_start;
    logic [SPP_W-1:0] cfg_spp_eff;
    logic [SPP_W-1:0] cur_spp;
    logic             cur_has;
    logic [63:0]      item_ts;
    logic [63:0]      cur_pkt_ts;
    logic [SPP_W:0]   items;
    logic             pkt_end;

    assign out_en        = !m_valid_q || m_axis_tready;
    assign s_axis_tready = rdy_q && out_en;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_valid_q && m_axis_tready;

    // A packet starts whenever no items are pending; spp and packet timestamp
    // are taken from live inputs on that beat and from latched state otherwise.
    assign pkt_start   = (cnt_q == '0);
    assign cfg_spp_eff = (cfg_spp == '0) ? SPP_W'(1) : cfg_spp;
    assign cur_spp     = pkt_start ? cfg_spp_eff : spp_q;
    assign cur_has     = (state_q == StIdle) ? s_axis_thas_time : has_time_q;
    assign item_ts     = (state_q == StIdle) ? s_axis_ttimestamp : nxt_ts_q;
    assign cur_pkt_ts  = pkt_start ? item_ts : pkt_ts_q;

    // Items in the packet including the current beat; a boundary coinciding
    // with s_axis_tlast closes a single packet.
    assign items   = {1'b0, cnt_q} + (SPP_W + 1)'(1);
    assign pkt_end = (items == {1'b0, cur_spp}) || s_axis_tlast;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        spp_d      = spp_q;
        pkt_ts_d   = pkt_ts_q;
        nxt_ts_d   = nxt_ts_q;
        has_time_d = has_time_q;
        if (s_fire) begin
            state_d    = s_axis_tlast ? StIdle : StBurst;
            cnt_d      = pkt_end ? '0 : items[SPP_W-1:0];
            spp_d      = cur_spp;
            pkt_ts_d   = cur_pkt_ts;
            nxt_ts_d   = item_ts + 64'd1;
            has_time_d = cur_has;
        end
    end

    always_comb begin
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        m_ts_d       = m_ts_q;
        m_has_time_d = m_has_time_q;
        m_len_d      = m_len_q;
        m_eob_d      = m_eob_q;
        if (out_en) begin
            m_valid_d = s_fire;
        end
        if (s_fire) begin
            m_data_d     = s_axis_tdata;
            m_last_d     = pkt_end;
            m_ts_d       = cur_pkt_ts;
            m_has_time_d = cur_has;
            m_len_d      = 16'(32'(items) * ItemBytes);
            m_eob_d      = s_axis_tlast;
        end
        pkt_cnt_d = pkt_cnt_q + ((m_fire && m_last_q) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            spp_q        <= '0;
            pkt_ts_q     <= '0;
            nxt_ts_q     <= '0;
            has_time_q   <= 1'b0;
            rdy_q        <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_ts_q       <= '0;
            m_has_time_q <= 1'b0;
            m_len_q      <= '0;
            m_eob_q      <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            spp_q        <= spp_d;
            pkt_ts_q     <= pkt_ts_d;
            nxt_ts_q     <= nxt_ts_d;
            has_time_q   <= has_time_d;
            rdy_q        <= 1'b1;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            m_ts_q       <= m_ts_d;
            m_has_time_q <= m_has_time_d;
            m_len_q      <= m_len_d;
            m_eob_q      <= m_eob_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign m_axis_tdata      = m_data_q;
    assign m_axis_tlast      = m_last_q;
    assign m_axis_tvalid     = m_valid_q;
    assign m_axis_ttimestamp = m_ts_q;
    assign m_axis_thas_time  = m_has_time_q;
    assign m_axis_tlength    = m_len_q;
    assign m_axis_teob       = m_eob_q;
    assign pkt_count         = pkt_cnt_q;

endmodule

// File: tb/tb_axis_sc_packetizer.sv
// Directed bench for axis_sc_packetizer (NUM_CHAN=1, ITEM_W=32, SPP_W=16).
module tb_axis_sc_packetizer;

    localparam int SPP_W = 16;

    logic        ce_clk = 1'b0;
    logic        ce_rst_n = 1'b0;
    logic [15:0] cfg_spp = 16'd4;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_ttimestamp = '0;
    logic        s_axis_thas_time = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [63:0] m_axis_ttimestamp;
    logic        m_axis_thas_time;
    logic [15:0] m_axis_tlength;
    logic        m_axis_teob;
    logic [31:0] pkt_count;

    axis_sc_packetizer #(
        .NUM_CHAN (1),
        .ITEM_W   (32),
        .SPP_W    (SPP_W)
    ) dut (
        .ce_clk            (ce_clk),
        .ce_rst_n          (ce_rst_n),
        .cfg_spp           (cfg_spp),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_ttimestamp (s_axis_ttimestamp),
        .s_axis_thas_time  (s_axis_thas_time),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_ttimestamp (m_axis_ttimestamp),
        .m_axis_thas_time  (m_axis_thas_time),
        .m_axis_tlength    (m_axis_tlength),
        .m_axis_teob       (m_axis_teob),
        .pkt_count         (pkt_count)
    );

    always #5 ce_clk = ~ce_clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        eob;
        logic [63:0] ts;
        logic        has;
        logic [15:0] len;
    } beat_t;

    beat_t obs[$];
    int    checks = 0;
    int    fails  = 0;
    logic  rand_ready = 1'b0;
    logic  ready_force = 1'b1;

    // Output-side ready, changed only just after the rising edge
    always @(posedge ce_clk) begin
        #1;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Record every output beat that will transfer on the coming rising edge
    always @(negedge ce_clk) begin
        beat_t b;
        if (ce_rst_n && m_axis_tvalid && m_axis_tready) begin
            b.data = m_axis_tdata;
            b.last = m_axis_tlast;
            b.eob  = m_axis_teob;
            b.ts   = m_axis_ttimestamp;
            b.has  = m_axis_thas_time;
            b.len  = m_axis_tlength;
            obs.push_back(b);
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int guard = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(negedge ce_clk);
        while (!s_axis_tready && guard < 200) begin
            guard++;
            @(negedge ce_clk);
        end
        chk("send_ready", 64'(s_axis_tready), 64'd1);
        @(posedge ce_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Burst of n items; timestamp/has_time inputs are scrambled after the
    // first item and cfg_spp may be changed at item chg_idx.
    task automatic burst(input int n, input logic [31:0] base, input logic [63:0] ts,
                         input logic has, input int chg_idx, input logic [15:0] chg_val);
        s_axis_ttimestamp = ts;
        s_axis_thas_time  = has;
        for (int i = 0; i < n; i++) begin
            if (i == chg_idx) cfg_spp = chg_val;
            if (i == 1) begin
                s_axis_ttimestamp = ~ts;
                s_axis_thas_time  = ~has;
            end
            send(base + 32'(i), i == n - 1);
        end
    endtask

    task automatic drain();
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        repeat (5) @(posedge ce_clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input int n, input logic [31:0] base,
                                input logic [31:0] last_mask);
        chk($sformatf("%s_count", tag), 64'(obs.size()), 64'(n));
        for (int i = 0; i < n && i < obs.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 64'(obs[i].data), 64'(base + 32'(i)));
            chk($sformatf("%s_last%0d", tag, i), 64'(obs[i].last), 64'(last_mask[i]));
        end
    endtask

    task automatic check_pkt(input string tag, input int idx, input logic [63:0] ts,
                             input logic has, input logic [15:0] len, input logic eob);
        if (idx < obs.size()) begin
            chk($sformatf("%s_ts%0d", tag, idx), obs[idx].ts, ts);
            chk($sformatf("%s_has%0d", tag, idx), 64'(obs[idx].has), 64'(has));
            chk($sformatf("%s_len%0d", tag, idx), 64'(obs[idx].len), 64'(len));
            chk($sformatf("%s_eob%0d", tag, idx), 64'(obs[idx].eob), 64'(eob));
        end else begin
            chk($sformatf("%s_missing%0d", tag, idx), 64'(obs.size()), 64'(idx + 1));
        end
    endtask

    task automatic do_reset();
        @(posedge ce_clk);
        #1;
        ce_rst_n = 1'b0;
        #2;
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_ts", m_axis_ttimestamp, 64'd0);
        chk("rst_len", 64'(m_axis_tlength), 64'd0);
        chk("rst_eob", 64'(m_axis_teob), 64'd0);
        chk("rst_pktcnt", 64'(pkt_count), 64'd0);
        repeat (2) @(posedge ce_clk);
        #1;
        ce_rst_n = 1'b1;
        obs.delete();
        chk("rel_tready_low", 64'(s_axis_tready), 64'd0);
        @(posedge ce_clk);
        #1;
        chk("rel_tready_high", 64'(s_axis_tready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Initial reset (includes a previously dirty pkt_count of 3 below)
        repeat (2) @(posedge ce_clk);
        do_reset();

        // 10-item burst, spp=4, ts=100 with has_time
        cfg_spp = 16'd4;
        burst(10, 32'h100, 64'd100, 1'b1, -1, 16'd0);
        drain();
        check_stream("s10", 10, 32'h100, 32'h288);
        check_pkt("s10", 3, 64'd100, 1'b1, 16'd16, 1'b0);
        check_pkt("s10", 7, 64'd104, 1'b1, 16'd16, 1'b0);
        check_pkt("s10", 9, 64'd108, 1'b1, 16'd8, 1'b1);
        chk("s10_pktcnt", 64'(pkt_count), 64'd3);

        // 8-item burst, spp=4: boundary coincides with tlast
        do_reset();
        obs.delete();
        burst(8, 32'h200, 64'd7, 1'b1, -1, 16'd0);
        drain();
        check_stream("s8", 8, 32'h200, 32'h88);
        check_pkt("s8", 3, 64'd7, 1'b1, 16'd16, 1'b0);
        check_pkt("s8", 7, 64'd11, 1'b1, 16'd16, 1'b1);
        chk("s8_pktcnt", 64'(pkt_count), 64'd2);

        // spp changed 4 -> 2 mid-packet
        obs.delete();
        cfg_spp = 16'd4;
        burst(8, 32'h300, 64'd0, 1'b0, 2, 16'd2);
        drain();
        check_stream("chg", 8, 32'h300, 32'hA8);
        check_pkt("chg", 3, 64'd0, 1'b0, 16'd16, 1'b0);
        check_pkt("chg", 5, 64'd4, 1'b0, 16'd8, 1'b0);
        check_pkt("chg", 7, 64'd6, 1'b0, 16'd8, 1'b1);
        chk("chg_pktcnt", 64'(pkt_count), 64'd5);

        // Timestamp wrap: 2^64-2, spp=2, 6 items
        obs.delete();
        cfg_spp = 16'd2;
        burst(6, 32'h400, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, -1, 16'd0);
        drain();
        check_stream("wrap", 6, 32'h400, 32'h2A);
        check_pkt("wrap", 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 16'd8, 1'b0);
        check_pkt("wrap", 3, 64'd0, 1'b1, 16'd8, 1'b0);
        check_pkt("wrap", 5, 64'd2, 1'b1, 16'd8, 1'b1);
        chk("wrap_pktcnt", 64'(pkt_count), 64'd8);

        // cfg_spp=0 acts as 1
        obs.delete();
        cfg_spp = 16'd0;
        burst(3, 32'h500, 64'h40, 1'b1, -1, 16'd0);
        drain();
        check_stream("spp0", 3, 32'h500, 32'h7);
        check_pkt("spp0", 0, 64'h40, 1'b1, 16'd4, 1'b0);
        check_pkt("spp0", 2, 64'h42, 1'b1, 16'd4, 1'b1);
        chk("spp0_pktcnt", 64'(pkt_count), 64'd11);

        // Back-pressure: output register and counters hold while tready=0
        obs.delete();
        cfg_spp = 16'd4;
        ready_force = 1'b0;
        @(posedge ce_clk);
        #1;
        burst(1, 32'hAA, 64'd9, 1'b1, -1, 16'd0);
        repeat (3) begin
            @(negedge ce_clk);
            chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
            chk("hold_data", 64'(m_axis_tdata), 64'hAA);
            chk("hold_sready", 64'(s_axis_tready), 64'd0);
            chk("hold_pktcnt", 64'(pkt_count), 64'd11);
        end
        @(posedge ce_clk);
        #1;
        drain();
        check_stream("hold", 1, 32'hAA, 32'h1);
        check_pkt("hold", 0, 64'd9, 1'b1, 16'd4, 1'b1);
        chk("hold_pktcnt_after", 64'(pkt_count), 64'd12);

        // Random output ready, 20 items, spp=3
        obs.delete();
        cfg_spp = 16'd3;
        rand_ready = 1'b1;
        burst(20, 32'h600, 64'h5000, 1'b1, -1, 16'd0);
        drain();
        check_stream("rnd", 20, 32'h600, 32'hA4924);
        check_pkt("rnd", 17, 64'h500F, 1'b1, 16'd12, 1'b0);
        check_pkt("rnd", 19, 64'h5012, 1'b1, 16'd8, 1'b1);
        chk("rnd_pktcnt", 64'(pkt_count), 64'd19);

        // Reset mid-burst discards the partial packet
        do_reset();
        cfg_spp = 16'd4;
        for (int i = 0; i < 3; i++) send(32'h700 + 32'(i), 1'b0);
        ce_rst_n = 1'b0;
        @(posedge ce_clk);
        #1;
        ce_rst_n = 1'b1;
        obs.delete();
        @(posedge ce_clk);
        #1;
        burst(4, 32'h800, 64'h20, 1'b1, -1, 16'd0);
        drain();
        check_stream("rstmid", 4, 32'h800, 32'h8);
        check_pkt("rstmid", 3, 64'h20, 1'b1, 16'd16, 1'b1);
        chk("rstmid_pktcnt", 64'(pkt_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
